// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS main controller: Moore FSM sequencing fetch/decode/execute/
// memory/writeback and driving every datapath enable and mux select.
module mc_control_fsm #(
  parameter int unsigned STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic               zero,
  output logic               IRwrite,
  output logic               PCWrite,
  output logic               Branch,
  output logic               pc_en,
  output logic               IorD,
  output logic               MemWrite,
  output logic               RegWrite,
  output logic               RegDst,
  output logic               MemtoReg,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ALUOp,
  output logic [1:0]         PCSrc,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [STATE_W-1:0] {
    FETCH   = STATE_W'(0),
    DECODE  = STATE_W'(1),
    MEMADR  = STATE_W'(2),
    MEMRD   = STATE_W'(3),
    MEMWB   = STATE_W'(4),
    MEMWR   = STATE_W'(5),
    EXECUTE = STATE_W'(6),
    ALUWB   = STATE_W'(7),
    BRANCH  = STATE_W'(8),
    ADDIEX  = STATE_W'(9),
    ADDIWB  = STATE_W'(10),
    JUMP    = STATE_W'(11)
  } state_e;

  state_e state_q, state_d;
  logic   illegal_q, illegal_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = FETCH;
    illegal_d = illegal_q;
    case (state_q)
      FETCH: state_d = DECODE;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXECUTE;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
          default: begin
            state_d   = FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        if (opcode == OP_LW)      state_d = MEMRD;
        else if (opcode == OP_SW) state_d = MEMWR;
        else                      state_d = FETCH;
      end
      MEMRD:   state_d = MEMWB;
      EXECUTE: state_d = ALUWB;
      ADDIEX:  state_d = ADDIWB;
      default: state_d = FETCH;
    endcase
  end

  // Outputs depend on state only; reset gates the write enables so no
  // partial write escapes while an aborted instruction is being flushed.
  always_comb begin
    IRwrite  = 1'b0;
    PCWrite  = 1'b0;
    Branch   = 1'b0;
    IorD     = 1'b0;
    MemWrite = 1'b0;
    RegWrite = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = '0;
    ALUOp    = '0;
    PCSrc    = '0;
    case (state_q)
      FETCH: begin
        IRwrite = 1'b1;
        PCWrite = 1'b1;
        ALUSrcB = 2'b01;
      end
      DECODE: ALUSrcB = 2'b11;
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEMRD: IorD = 1'b1;
      MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      EXECUTE: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      ALUWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      BRANCH: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b01;
        Branch  = 1'b1;
        PCSrc   = 2'b01;
      end
      ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      ADDIWB: RegWrite = 1'b1;
      JUMP: begin
        PCWrite = 1'b1;
        PCSrc   = 2'b10;
      end
      default: ;
    endcase
    if (reset) begin
      IRwrite  = 1'b0;
      PCWrite  = 1'b0;
      Branch   = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
    end
    pc_en = PCWrite | (Branch & zero);
  end

  assign illegal_op = illegal_q;
  assign state      = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: directed vector table for the documented
// instruction flows, then random instruction streams against a sequence model.
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       reset, zero;
  logic [5:0] opcode;
  logic       IRwrite, PCWrite, Branch, pc_en, IorD, MemWrite, RegWrite;
  logic       RegDst, MemtoReg, ALUSrcA, illegal_op;
  logic [1:0] ALUSrcB, ALUOp, PCSrc;
  logic [3:0] state;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mc_control_fsm #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
    .IRwrite(IRwrite), .PCWrite(PCWrite), .Branch(Branch), .pc_en(pc_en),
    .IorD(IorD), .MemWrite(MemWrite), .RegWrite(RegWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSrc(PCSrc), .illegal_op(illegal_op), .state(state)
  );

  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic       z;
    int         st;
    logic       pc;
    logic [4:0] wr;   // {IRwrite, PCWrite, Branch, MemWrite, RegWrite}
    logic       ill;
  } row_t;

  typedef int iq_t[$];

  row_t rows[$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic add(input logic rst, input logic [5:0] op, input logic z,
                     input int st, input logic pc, input logic [4:0] wr,
                     input logic ill);
    row_t r;
    r.rst = rst; r.op = op; r.z = z; r.st = st; r.pc = pc; r.wr = wr; r.ill = ill;
    rows.push_back(r);
  endtask

  // State visit order of a whole instruction, FETCH included.
  function automatic iq_t seq_of(input logic [5:0] op);
    iq_t s;
    case (op)
      6'b000000: s = '{0, 1, 6, 7};
      6'b100011: s = '{0, 1, 2, 3, 4};
      6'b101011: s = '{0, 1, 2, 5};
      6'b000100: s = '{0, 1, 8};
      6'b001000: s = '{0, 1, 9, 10};
      6'b000010: s = '{0, 1, 11};
      default:   s = '{0, 1};
    endcase
    return s;
  endfunction

  // {IRwrite,PCWrite,Branch,pc_en,IorD,MemWrite,RegWrite,RegDst,MemtoReg,ALUSrcA,ALUSrcB,ALUOp,PCSrc}
  function automatic logic [15:0] exp_ctl(input int st, input logic rst, input logic z);
    logic ir, pcw, br, pce, iord, mw, rw, rd, m2r, sa;
    logic [1:0] sb, aop, psrc;
    {ir, pcw, br, iord, mw, rw, rd, m2r, sa} = '0;
    sb = '0; aop = '0; psrc = '0;
    case (st)
      0:  begin ir = 1; pcw = 1; sb = 2'b01; end
      1:  sb = 2'b11;
      2:  begin sa = 1; sb = 2'b10; end
      3:  iord = 1;
      4:  begin rw = 1; m2r = 1; end
      5:  begin iord = 1; mw = 1; end
      6:  begin sa = 1; aop = 2'b10; end
      7:  begin rw = 1; rd = 1; end
      8:  begin sa = 1; aop = 2'b01; br = 1; psrc = 2'b01; end
      9:  begin sa = 1; sb = 2'b10; end
      10: rw = 1;
      11: begin pcw = 1; psrc = 2'b10; end
      default: ;
    endcase
    if (rst) {ir, pcw, br, mw, rw} = '0;
    pce = pcw | (br & z);
    return {ir, pcw, br, pce, iord, mw, rw, rd, m2r, sa, sb, aop, psrc};
  endfunction

  function automatic logic is_legal(input logic [5:0] op);
    return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
  endfunction

  logic [15:0] act_ctl;
  assign act_ctl = {IRwrite, PCWrite, Branch, pc_en, IorD, MemWrite, RegWrite,
                    RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSrc};

  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BQ = 6'b000100, AD = 6'b001000, JP = 6'b000010, BAD = 6'b111111;

  initial begin
    logic [5:0] mop;
    int         mpos;
    logic       mill;
    logic       rst;
    iq_t        sq;
    int         est;

    reset = 1'b1; opcode = '0; zero = 1'b0;
    @(negedge clk);

    // rst op z | state pc_en wr ill ; each row shows the state the DUT is in
    add(1, R,  0,  0, 0, 5'b00000, 0);
    add(1, R,  0,  0, 0, 5'b00000, 0);
    add(0, R,  0,  0, 1, 5'b11000, 0);
    add(0, R,  0,  1, 0, 5'b00000, 0);
    add(0, R,  0,  6, 0, 5'b00000, 0);
    add(0, R,  0,  7, 0, 5'b00001, 0);
    add(0, LW, 0,  0, 1, 5'b11000, 0);
    add(0, LW, 0,  1, 0, 5'b00000, 0);
    add(0, LW, 0,  2, 0, 5'b00000, 0);
    add(0, LW, 0,  3, 0, 5'b00000, 0);
    add(0, LW, 0,  4, 0, 5'b00001, 0);
    add(0, SW, 0,  0, 1, 5'b11000, 0);
    add(0, SW, 0,  1, 0, 5'b00000, 0);
    add(0, SW, 0,  2, 0, 5'b00000, 0);
    add(0, SW, 0,  5, 0, 5'b00010, 0);
    add(0, BQ, 1,  0, 1, 5'b11000, 0);
    add(0, BQ, 1,  1, 0, 5'b00000, 0);
    add(0, BQ, 1,  8, 1, 5'b00100, 0);
    add(0, BQ, 0,  0, 1, 5'b11000, 0);
    add(0, BQ, 0,  1, 0, 5'b00000, 0);
    add(0, BQ, 0,  8, 0, 5'b00100, 0);
    add(0, AD, 0,  0, 1, 5'b11000, 0);
    add(0, AD, 0,  1, 0, 5'b00000, 0);
    add(0, AD, 0,  9, 0, 5'b00000, 0);
    add(0, AD, 0, 10, 0, 5'b00001, 0);
    add(0, JP, 0,  0, 1, 5'b11000, 0);
    add(0, JP, 0,  1, 0, 5'b00000, 0);
    add(0, JP, 0, 11, 1, 5'b01000, 0);
    add(0, BAD,0,  0, 1, 5'b11000, 0);
    add(0, BAD,0,  1, 0, 5'b00000, 0);
    add(0, LW, 0,  0, 1, 5'b11000, 1);
    add(0, LW, 0,  1, 0, 5'b00000, 1);
    add(0, LW, 0,  2, 0, 5'b00000, 1);
    add(1, LW, 0,  3, 0, 5'b00000, 1);
    add(0, LW, 0,  0, 1, 5'b11000, 0);
    add(0, LW, 0,  1, 0, 5'b00000, 0);

    for (int i = 0; i < rows.size(); i++) begin
      reset = rows[i].rst; opcode = rows[i].op; zero = rows[i].z;
      #1;
      chk($sformatf("row%0d state", i), int'(state), rows[i].st);
      chk($sformatf("row%0d pc_en", i), int'(pc_en), int'(rows[i].pc));
      chk($sformatf("row%0d wr", i), int'({IRwrite, PCWrite, Branch, MemWrite, RegWrite}),
          int'(rows[i].wr));
      chk($sformatf("row%0d illegal_op", i), int'(illegal_op), int'(rows[i].ill));
      @(negedge clk);
    end

    mop = '0; mpos = 0; mill = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      rst = (i == 0) || ($urandom_range(0, 39) == 0);
      if (mpos == 0) begin
        case ($urandom_range(0, 7))
          0: opcode = R;  1: opcode = LW; 2: opcode = SW;
          3: opcode = BQ; 4: opcode = AD; 5: opcode = JP;
          default: opcode = 6'($urandom_range(0, 63));
        endcase
      end
      zero  = 1'($urandom_range(0, 1));
      reset = rst;
      #1;
      sq  = seq_of(mop);
      est = (mpos == 0) ? 0 : sq[mpos];
      if (i < 3) begin
        // Model is being synchronised by the forced reset on cycle 0.
        chk($sformatf("rnd%0d ctl", i), int'(act_ctl), int'(exp_ctl(int'(state), rst, zero)));
      end else begin
        chk($sformatf("rnd%0d state", i), int'(state), est);
        chk($sformatf("rnd%0d ctl", i), int'(act_ctl), int'(exp_ctl(est, rst, zero)));
        chk($sformatf("rnd%0d illegal_op", i), int'(illegal_op), int'(mill));
      end
      if (rst) begin
        mpos = 0; mill = 1'b0;
      end else if (mpos == 0) begin
        mop = opcode; mpos = 1;
      end else begin
        if (mpos == 1 && !is_legal(mop)) mill = 1'b1;
        mpos++;
        if (mpos >= seq_of(mop).size()) mpos = 0;
      end
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Main control unit of the multi-cycle MIPS processor.
- Sits directly downstream of the instruction register and takes opcode bits [31:26] of the latched instruction.
- Sequences each instruction through fetch/decode/execute/memory/writeback states.
- Drives all datapath enables and mux selects, including the IRwrite strobe that loads the instruction register.

Parameters:
- STATE_W, 4, width of the state register and of the state debug port.

Ports:
- clk  input  1  system clock, all state changes on rising edge
- reset  input  1  synchronous, active-high; forces FETCH
- opcode  input  6  instruction_register[31:26]
- zero  input  1  ALU zero flag, used for beq
- IRwrite  output  1  load instruction register from memory_out
- PCWrite  output  1  unconditional PC write
- Branch  output  1  conditional PC write
- pc_en  output  1  PCWrite | (Branch & zero)
- IorD  output  1  memory address select: 0=PC, 1=ALUOut
- MemWrite  output  1  data memory write
- RegWrite  output  1  register file write
- RegDst  output  1  0=rt, 1=rd
- MemtoReg  output  1  0=ALUOut, 1=MDR
- ALUSrcA  output  1  0=PC, 1=A
- ALUSrcB  output  2  00=B, 01=const 4, 10=SignImm, 11=SignImm<<2
- ALUOp  output  2  00=add, 01=sub, 10=funct-decoded
- PCSrc  output  2  00=ALUResult, 01=ALUOut, 10=jump target
- illegal_op  output  1  sticky flag, unsupported opcode decoded
- state  output  STATE_W  current state, debug

Behaviour:
- Moore machine: every output except pc_en is a function of the state only. pc_en is combinational.
- Any output not listed for a state is 0.
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- States, encodings, asserted outputs and transitions:
  - FETCH(0): IRwrite=1, PCWrite=1, ALUSrcB=01, ALUOp=00, IorD=0 -> DECODE.
  - DECODE(1): ALUSrcB=11 (branch target precompute).
    - lw/sw -> MEMADR
    - R -> EXECUTE
    - beq -> BRANCH
    - addi -> ADDIEX
    - j -> JUMP
    - other -> FETCH, and illegal_op is set on the same edge.
  - MEMADR(2): ALUSrcA=1, ALUSrcB=10 -> MEMRD if lw, MEMWR if sw.
  - MEMRD(3): IorD=1 -> MEMWB.
  - MEMWB(4): RegWrite=1, MemtoReg=1, RegDst=0 -> FETCH.
  - MEMWR(5): IorD=1, MemWrite=1 -> FETCH.
  - EXECUTE(6): ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> ALUWB.
  - ALUWB(7): RegWrite=1, RegDst=1, MemtoReg=0 -> FETCH.
  - BRANCH(8): ALUSrcA=1, ALUSrcB=00, ALUOp=01, Branch=1, PCSrc=01 -> FETCH.
  - ADDIEX(9): ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> ADDIWB.
  - ADDIWB(10): RegWrite=1, RegDst=0 -> FETCH.
  - JUMP(11): PCWrite=1, PCSrc=10 -> FETCH.
  - Encodings 12-15 are unreachable; if entered, next state is FETCH.
- Cycle counts, including FETCH: lw 5, sw 4, R 4, addi 4, beq 3, j 3, illegal 2.
- Opcode is sampled only in DECODE and MEMADR. It must stay stable from the FETCH edge onward, which holds because IRwrite is 0 outside FETCH.
- Reset:
  - While reset=1, all write enables (IRwrite, PCWrite, Branch, MemWrite, RegWrite, pc_en) are forced to 0 regardless of state.
  - Next edge: state=FETCH, illegal_op=0.
  - Reset in any state, including mid-lw, aborts the instruction; no partial write occurs after reset is sampled.
- illegal_op stays 1 until reset. The processor continues fetching after an illegal opcode.
- In BRANCH, pc_en = zero. In FETCH and JUMP, pc_en = 1 regardless of zero.

Test Plan:
- Reset held 2 cycles, then released -> state=0, IRwrite=1, PCWrite=1, pc_en=1 in the first cycle after release; all enables 0 while reset=1.
- opcode=000000 (IR=32'h0000_2008) -> states 0,1,6,7,0; RegWrite=1 and RegDst=1 only in state 7; IRwrite high only in state 0.
- opcode=100011 then 101011 back to back -> lw: 0,1,2,3,4 with MemtoReg=1 in 4; sw: 0,1,2,5 with MemWrite=1 for exactly one cycle.
- opcode=000100 with zero=1, then with zero=0 -> state 8 pc_en=1 with PCSrc=01; then pc_en=0; each 3 cycles total.
- opcode=001000 and 000010 -> addi: 0,1,9,10; j: 0,1,11 with PCSrc=10, pc_en=1.
- opcode=111111 -> DECODE returns to FETCH, illegal_op=1 and stays set; reset asserted in state 3 of a following lw -> next state 0, no RegWrite pulse, illegal_op=0.
